i2c_slave_regfile: RTL

Synthesizable I2C slave with an internal parametrised register file. It connects to the same open-drain pad triplets as the Wishbone I2C master core, so master-core benches can run against real RTL instead of a behavioural slave model. It supports multi-byte auto-increment writes and reads, repeated START, glitch-filtered inputs and optional clock stretching. A local host port exposes register contents and write events.

---
 rtl/i2c_slave_regfile.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: I2C slave with an 8-bit register file and auto-increment pointer.
// Pads follow the open-drain triplet style: *_pad_o is tied low and *_padoen_o (active low)
// decides whether the line is pulled down.
// Optional macro I2CS_STRETCH_EN: hold SCL low for STRETCH cycles after every ACK/RACK bit.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h02,
  parameter int         ADDR_BITS  = 4,
  parameter int         FILT       = 3,
  parameter int         STRETCH    = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 arst_i,
  input  logic                 scl_pad_i,
  output logic                 scl_pad_o,
  output logic                 scl_padoen_o,
  input  logic                 sda_pad_i,
  output logic                 sda_pad_o,
  output logic                 sda_padoen_o,
  input  logic [ADDR_BITS-1:0] host_adr_i,
  output logic [7:0]           host_dat_o,
  output logic                 wr_stb_o,
  output logic [ADDR_BITS-1:0] wr_adr_o,
  output logic                 busy_o
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int SW    = (STRETCH < 2) ? 1 : $clog2(STRETCH + 1);

`ifdef I2CS_STRETCH_EN
  localparam bit STRETCH_EN = 1'b1;
`else
  localparam bit STRETCH_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK
  } state_t;

  // Index 0 = SCL, index 1 = SDA
  logic [1:0] pad_in;
  logic [1:0] lvl;
  logic [1:0] lvl_prev;
  assign pad_in = {sda_pad_i, scl_pad_i};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_in
      logic [1:0] sync_q;
      logic [2:0] cnt_q;
      logic       lvl_q;
      logic       prev_q;
      // Synchronise, then accept a new level only after FILT identical samples
      always_ff @(posedge wb_clk_i or posedge arst_i) begin
        if (arst_i) begin
          sync_q <= 2'b11;
          cnt_q  <= '0;
          lvl_q  <= 1'b1;
          prev_q <= 1'b1;
        end else begin
          sync_q <= {sync_q[0], pad_in[gi]};
          prev_q <= lvl_q;
          if (sync_q[1] == lvl_q) begin
            cnt_q <= '0;
          end else if (cnt_q == 3'(FILT - 1)) begin
            lvl_q <= sync_q[1];
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
      end
      assign lvl[gi]      = lvl_q;
      assign lvl_prev[gi] = prev_q;
    end
  endgenerate

  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
  assign scl_f     = lvl[0];
  assign sda_f     = lvl[1];
  assign scl_rise  = scl_f & ~lvl_prev[0];
  assign scl_fall  = ~scl_f & lvl_prev[0];
  assign start_det = scl_f & lvl_prev[0] & lvl_prev[1] & ~sda_f;
  assign stop_det  = scl_f & lvl_prev[0] & ~lvl_prev[1] & sda_f;

  state_t               state_q;
  logic [3:0]           bit_cnt_q;
  logic [7:0]           sh_q;
  logic [ADDR_BITS-1:0] ptr_q;
  logic                 ack_ok_q;
  logic                 sda_oen_q;
  logic                 busy_q;
  logic                 wr_stb_q;
  logic [ADDR_BITS-1:0] wr_adr_q;
  logic [7:0]           mem_q [DEPTH];

  logic [7:0]           byte_in;
  logic [ADDR_BITS-1:0] ptr_inc;
  assign byte_in = {sh_q[6:0], sda_f};
  assign ptr_inc = ptr_q + ADDR_BITS'(1);

  // Protocol FSM: bit shifting, ACK driving, register writes and read reloads
  always_ff @(posedge wb_clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      ptr_q     <= '0;
      ack_ok_q  <= 1'b0;
      sda_oen_q <= 1'b1;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_adr_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_stb_q <= 1'b0;
      if (start_det) begin
        state_q   <= S_ADDR;
        bit_cnt_q <= '0;
        busy_q    <= 1'b1;
        sda_oen_q <= 1'b1;
      end else if (stop_det) begin
        state_q   <= S_IDLE;
        busy_q    <= 1'b0;
        sda_oen_q <= 1'b1;
      end else begin
        unique case (state_q)
          S_ADDR, S_PTR, S_WDATA: begin
            if (scl_rise && bit_cnt_q < 4'd8) begin
              sh_q      <= byte_in;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7 && state_q == S_PTR) ptr_q <= byte_in[ADDR_BITS-1:0];
              if (bit_cnt_q == 4'd7 && state_q == S_WDATA) begin
                mem_q[ptr_q] <= byte_in;
                wr_stb_q     <= 1'b1;
                wr_adr_q     <= ptr_q;
                ptr_q        <= ptr_inc;
              end
            end else if (scl_fall && bit_cnt_q == 4'd8) begin
              bit_cnt_q <= '0;
              if (state_q == S_ADDR && sh_q[7:1] != SLAVE_ADDR) begin
                state_q <= S_IDLE;  // not addressed: leave SDA released
              end else begin
                sda_oen_q <= 1'b0;
                case (state_q)
                  S_ADDR:  state_q <= S_ADDR_ACK;
                  S_PTR:   state_q <= S_PTR_ACK;
                  default: state_q <= S_WDATA_ACK;
                endcase
              end
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt_q <= '0;
              if (sh_q[0]) begin
                // Read: the first data bit goes out on the same fall that ends the ACK
                sda_oen_q <= mem_q[ptr_q][7];
                sh_q      <= {mem_q[ptr_q][6:0], 1'b0};
                state_q   <= S_RDATA;
              end else begin
                sda_oen_q <= 1'b1;
                state_q   <= S_PTR;
              end
            end
          end
          S_PTR_ACK, S_WDATA_ACK: begin
            if (scl_fall) begin
              sda_oen_q <= 1'b1;
              bit_cnt_q <= '0;
              state_q   <= S_WDATA;
            end
          end
          S_RDATA: begin
            if (scl_rise && bit_cnt_q < 4'd8) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                sda_oen_q <= 1'b1;
                bit_cnt_q <= '0;
                ack_ok_q  <= 1'b0;
                state_q   <= S_RACK;
              end else begin
                sda_oen_q <= sh_q[7];
                sh_q      <= {sh_q[6:0], 1'b0};
              end
            end
          end
          S_RACK: begin
            if (scl_rise) begin
              ack_ok_q <= ~sda_f;
            end else if (scl_fall) begin
              if (ack_ok_q) begin
                ptr_q     <= ptr_inc;
                sda_oen_q <= mem_q[ptr_inc][7];
                sh_q      <= {mem_q[ptr_inc][6:0], 1'b0};
                state_q   <= S_RDATA;
              end else begin
                state_q <= S_IDLE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // The SCL fall that ends an ACK/RACK bit is where a stretch may begin
  logic ack_end;
  assign ack_end = scl_fall && !start_det && !stop_det &&
                   (state_q == S_ADDR_ACK || state_q == S_PTR_ACK ||
                    state_q == S_WDATA_ACK || state_q == S_RACK);

  logic          scl_oen_q;
  logic [SW-1:0] str_cnt_q;

  // SCL low-hold timer; bus conditions cancel it at once
  always_ff @(posedge wb_clk_i or posedge arst_i) begin
    if (arst_i) begin
      scl_oen_q <= 1'b1;
      str_cnt_q <= '0;
    end else if (start_det || stop_det) begin
      scl_oen_q <= 1'b1;
      str_cnt_q <= '0;
    end else if (STRETCH_EN && ack_end) begin
      scl_oen_q <= 1'b0;
      str_cnt_q <= SW'(STRETCH - 1);
    end else if (!scl_oen_q) begin
      if (str_cnt_q == '0) scl_oen_q <= 1'b1;
      else str_cnt_q <= str_cnt_q - SW'(1);
    end
  end

  assign scl_pad_o    = 1'b0;
  assign sda_pad_o    = 1'b0;
  assign scl_padoen_o = STRETCH_EN ? scl_oen_q : 1'b1;
  assign sda_padoen_o = sda_oen_q;
  assign host_dat_o   = mem_q[host_adr_i];
  assign wr_stb_o     = wr_stb_q;
  assign wr_adr_o     = wr_adr_q;
  assign busy_o       = busy_q;

endmodule
